// File: rtl/pk_hasti.sv
// HASTI (AHB-lite) bus types shared by the SRAM slave and its write buffer.
package pk_hasti;

    localparam int unsigned data_width = 32;
    localparam int unsigned be_width   = data_width / 8;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [2:0] {
        D_IDLE  = 3'd0,
        D_READ  = 3'd1,
        D_WRITE = 3'd2,
        D_ERR1  = 3'd3,
        D_ERR2  = 3'd4
    } dstate_t;

    // One posted write: lane enables plus data.
    typedef struct packed {
        logic [be_width-1:0]   be;
        logic [data_width-1:0] data;
    } hasti_wr_t;

    // Lane enables for a transfer; sizes above WORD collapse to a full word.
    function automatic logic [3:0] hasti_be(input hsize_t size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << a;
            HSIZE_HALF: be = 4'b0011 << {a[1], 1'b0};
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/hasti_wbuf.sv
// One-entry posted write buffer: load, commit, address compare and byte-merge read forwarding.
module hasti_wbuf
    import pk_hasti::*;
#(
    parameter int unsigned aw = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  commit,
    input  logic [aw-1:0]         ld_addr,
    input  logic [be_width-1:0]   ld_be,
    input  logic [data_width-1:0] ld_data,
    input  logic [aw-1:0]         rd_addr,
    input  logic [data_width-1:0] rd_sram,
    output logic                  wb_valid,
    output logic [aw-1:0]         wb_addr,
    output logic [be_width-1:0]   wb_be,
    output logic [data_width-1:0] wb_data,
    output logic [data_width-1:0] fwd_data_c
);

    logic      valid_q, valid_d;
    logic [aw-1:0] addr_q, addr_d;
    hasti_wr_t ent_q, ent_d;

    // A load in the same cycle as a commit keeps the buffer full with the new entry.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        ent_d   = ent_q;
        if (commit) valid_d = 1'b0;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = ld_addr;
            ent_d   = '{be: ld_be, data: ld_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            ent_q   <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            ent_q   <= ent_d;
        end
    end

    always_comb begin
        fwd_data_c = rd_sram;
        if (valid_q && (addr_q == rd_addr)) begin
            for (int i = 0; i < int'(be_width); i++) begin
                if (ent_q.be[i]) fwd_data_c[8*i +: 8] = ent_q.data[8*i +: 8];
            end
        end
    end

    assign wb_valid = valid_q;
    assign wb_addr  = addr_q;
    assign wb_be    = ent_q.be;
    assign wb_data  = ent_q.data;

endmodule

// File: rtl/hasti_sram_slave.sv
// HASTI (AHB-lite) slave onto a single-port synchronous SRAM, zero-wait via a posted write buffer.
// Optional HASTI_SRAM_ERR_EN: two-cycle ERROR for out-of-range, oversize or misaligned transfers.
module hasti_sram_slave #(
    parameter int unsigned  mem_words  = 4096,
    parameter int unsigned  data_width = pk_hasti::data_width,
    localparam int unsigned aw         = $clog2(mem_words)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hsel,
    input  logic [31:0]             haddr,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [1:0]              htrans,
    input  logic                    hmastlock,
    input  logic [3:0]              hprot,
    input  logic [data_width-1:0]   hwdata,
    output logic [data_width-1:0]   hrdata,
    output logic                    hready,
    output logic                    hresp,
    output logic                    sram_ce,
    output logic                    sram_we,
    output logic [data_width/8-1:0] sram_be,
    output logic [aw-1:0]           sram_addr,
    output logic [data_width-1:0]   sram_wdata,
    input  logic [data_width-1:0]   sram_rdata
);
    import pk_hasti::*;

    localparam int unsigned bw = data_width / 8;

    dstate_t          state_q, state_d;
    logic [aw-1:0]    dp_addr_q, dp_addr_d;
    logic [bw-1:0]    dp_be_q, dp_be_d;

    logic             addr_act, addr_err, rd_req, stall, acc, rd_issue;
    logic             wb_load, wb_commit, wb_valid;
    logic [aw-1:0]    req_addr, wb_addr;
    logic [bw-1:0]    req_be, wb_be;
    logic [data_width-1:0] wb_data, fwd_data;
    logic             unused_c;

    assign addr_act = hsel && (htrans_t'(htrans) inside {HTRANS_NONSEQ, HTRANS_SEQ});
    assign req_addr = haddr[aw+1:2];
    assign req_be   = hasti_be(hsize_t'(hsize), haddr[1:0]);
    assign unused_c = ^{hburst, hmastlock, hprot, haddr};

`ifdef HASTI_SRAM_ERR_EN
    logic misaligned;

    always_comb begin
        case (hsize_t'(hsize))
            HSIZE_BYTE: misaligned = 1'b0;
            HSIZE_HALF: misaligned = haddr[0];
            HSIZE_WORD: misaligned = |haddr[1:0];
            default:    misaligned = 1'b1;
        endcase
    end

    assign addr_err = misaligned || (haddr[31:2] >= 30'(mem_words));
`else
    assign addr_err = 1'b0;
`endif

    // Handshake, SRAM arbitration (read issue beats buffer commit) and next data phase.
    always_comb begin
        state_d   = state_q;
        dp_addr_d = dp_addr_q;
        dp_be_d   = dp_be_q;

        rd_req    = addr_act && !hwrite && !addr_err;
        stall     = (state_q == D_WRITE) && wb_valid && rd_req;
        hready    = !(stall || (state_q == D_ERR1));
        acc       = addr_act && hready;
        rd_issue  = acc && !hwrite && !addr_err;
        wb_load   = (state_q == D_WRITE) && hready;
        wb_commit = wb_valid && !rd_issue;

`ifdef HASTI_SRAM_ERR_EN
        hresp = ((state_q == D_ERR1) || (state_q == D_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
        hresp = HRESP_OKAY;
`endif

        if (!hready) begin
            if (state_q == D_ERR1) state_d = D_ERR2;
        end else if (acc) begin
            dp_addr_d = req_addr;
            dp_be_d   = req_be;
            if (addr_err)    state_d = D_ERR1;
            else if (hwrite) state_d = D_WRITE;
            else             state_d = D_READ;
        end else begin
            state_d = D_IDLE;
        end

        sram_ce    = rd_issue || wb_commit;
        sram_we    = wb_commit;
        sram_addr  = rd_issue ? req_addr : wb_addr;
        sram_be    = rd_issue ? '1 : wb_be;
        sram_wdata = wb_data;
        hrdata     = (state_q == D_READ) ? fwd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= D_IDLE;
            dp_addr_q <= '0;
            dp_be_q   <= '0;
        end else begin
            state_q   <= state_d;
            dp_addr_q <= dp_addr_d;
            dp_be_q   <= dp_be_d;
        end
    end

    hasti_wbuf #(.aw(aw)) u_wbuf (
        .clk        (clk),
        .reset      (reset),
        .load       (wb_load),
        .commit     (wb_commit),
        .ld_addr    (dp_addr_q),
        .ld_be      (dp_be_q),
        .ld_data    (hwdata),
        .rd_addr    (dp_addr_q),
        .rd_sram    (sram_rdata),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_be      (wb_be),
        .wb_data    (wb_data),
        .fwd_data_c (fwd_data)
    );

endmodule

// File: tb/tb_hasti_sram_slave.sv
// Bench for hasti_sram_slave: directed cases plus random traffic against an architectural memory model.
module tb_hasti_sram_slave;

    localparam int unsigned MW = 256;
    localparam int unsigned AW = $clog2(MW);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rst_nxt = 1'b1;
    logic        mem_clr = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = '0;
    logic [1:0]  htrans = '0;
    logic        hmastlock = 1'b0;
    logic [3:0]  hprot = '0;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    logic        hready, hresp;
    logic        sram_ce, sram_we;
    logic [3:0]  sram_be;
    logic [AW-1:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    hasti_sram_slave #(.mem_words(MW)) dut (
        .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .htrans(htrans), .hmastlock(hmastlock),
        .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
        .hresp(hresp), .sram_ce(sram_ce), .sram_we(sram_we), .sram_be(sram_be),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model.
    logic [31:0] smem [MW];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < int'(MW); i++) smem[i] <= '0;
        end else if (sram_ce) begin
            if (sram_we) begin
                for (int i = 0; i < 4; i++)
                    if (sram_be[i]) smem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
            end else begin
                sram_rdata <= smem[sram_addr];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural memory, the current data phase, and whether a write is still posted.
    typedef enum {M_NONE, M_READ, M_WRITE, M_ERR1, M_ERR2} mdp_e;
    logic [31:0] arch [MW];
    mdp_e        m_dp = M_NONE;
    int unsigned m_word = 0;
    logic [3:0]  m_be = '0;
    bit          m_pend = 1'b0;
    bit          last_hready = 1'b1;
    bit          last_acc_wr = 1'b0;

    function automatic int unsigned m_bytes(input logic [2:0] sz);
        return (sz >= 3'd2) ? 4 : (1 << sz);
    endfunction

    function automatic logic [3:0] m_be_of(input logic [2:0] sz, input logic [31:0] a);
        int unsigned n    = m_bytes(sz);
        int unsigned lane = ((a % 4) / n) * n;
        return 4'(((1 << n) - 1) << lane);
    endfunction

    function automatic bit m_err(input logic [2:0] sz, input logic [31:0] a);
`ifdef HASTI_SRAM_ERR_EN
        return (sz > 3'd2) || ((a % m_bytes(sz)) != 0) || ((a >> 2) >= MW);
`else
        return (sz > 3'd7) && (a == 32'hFFFF_FFFF);
`endif
    endfunction

    // Compare process: once per cycle, just before the rising edge.
    initial begin
        bit act, err, acc, rd, e_hready, e_hresp;
        int unsigned word;
        logic [31:0] e_hrdata;
        for (int i = 0; i < int'(MW); i++) arch[i] = '0;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                m_dp = M_NONE;
                m_pend = 1'b0;
                last_hready = 1'b1;
                last_acc_wr = 1'b0;
                continue;
            end
            act      = hsel && (htrans == 2'd2 || htrans == 2'd3);
            err      = act && m_err(hsize, haddr);
            word     = (haddr >> 2) % MW;
            e_hready = !(m_dp == M_ERR1) && !(m_dp == M_WRITE && m_pend && act && !hwrite && !err);
            e_hresp  = (m_dp == M_ERR1) || (m_dp == M_ERR2);
            e_hrdata = (m_dp == M_READ) ? arch[m_word] : 32'h0;
            check("hready", 32'(hready), 32'(e_hready));
            check("hresp", 32'(hresp), 32'(e_hresp));
            check("hrdata", hrdata, e_hrdata);
            acc = act && e_hready;
            rd  = acc && !hwrite && !err;
            check("sram_ce", 32'(sram_ce), 32'(rd || m_pend));
            if (rd) begin
                check("sram_rd_we", 32'(sram_we), 32'(0));
                check("sram_rd_addr", 32'(sram_addr), word);
            end else if (m_pend) begin
                check("sram_commit_we", 32'(sram_we), 32'(1));
            end
            if (m_dp == M_WRITE && e_hready) begin
                for (int i = 0; i < 4; i++)
                    if (m_be[i]) arch[m_word][8*i +: 8] = hwdata[8*i +: 8];
            end
            m_pend = (m_dp == M_WRITE && e_hready) ? 1'b1 : (rd ? m_pend : 1'b0);
            if (!e_hready) begin
                if (m_dp == M_ERR1) m_dp = M_ERR2;
            end else if (acc) begin
                m_word = word;
                m_be   = m_be_of(hsize, haddr);
                m_dp   = err ? M_ERR1 : (hwrite ? M_WRITE : M_READ);
            end else begin
                m_dp = M_NONE;
            end
            last_hready = hready;
            last_acc_wr = acc && hwrite;
        end
    end

    task automatic drive(input bit sel, input logic [1:0] tr, input bit wr,
                         input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        reset     = rst_nxt;
        hsel      = sel;
        htrans    = tr;
        hwrite    = wr;
        hsize     = sz;
        haddr     = a;
        hwdata    = wd;
        hburst    = 3'($urandom_range(0, 7));
        hmastlock = 1'($urandom_range(0, 1));
        hprot     = 4'($urandom_range(0, 15));
    endtask

    task automatic cyc(input bit sel, input logic [1:0] tr, input bit wr,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        drive(sel, tr, wr, sz, a, wd);
        #4;
    endtask

    task automatic idle(input logic [31:0] wd);
        cyc(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, wd);
    endtask

    initial begin
        int zeros;
        logic [31:0] a, wd;
        logic [2:0]  sz;
        int          r;

        repeat (3) idle(32'h0);
        rst_nxt = 1'b0;
        @(negedge clk);
        mem_clr = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0);
        #4;
        check("rst_hready", 32'(hready), 32'(1));
        check("rst_hresp", 32'(hresp), 32'(0));
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_sram_ce", 32'(sram_ce), 32'(0));

        // T1: posted word write, commit while idle, read back
        cyc(1'b1, 2'd2, 1'b1, 3'd2, 32'h10, 32'h0);
        idle(32'hDEADBEEF);
        check("t1_data_hready", 32'(hready), 32'(1));
        idle(32'h0);
        check("t1_commit", {30'h0, sram_ce, sram_we}, 32'h3);
        check("t1_commit_addr", 32'(sram_addr), 32'h4);
        check("t1_commit_wdata", sram_wdata, 32'hDEADBEEF);
        cyc(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
        idle(32'h0);
        check("t1_rdata", hrdata, 32'hDEADBEEF);

        // T2: write then read of the same word back to back
        cyc(1'b1, 2'd2, 1'b1, 3'd2, 32'h20, 32'h0);
        cyc(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h11223344);
        check("t2_hready", 32'(hready), 32'(1));
        idle(32'h0);
        check("t2_fwd", hrdata, 32'h11223344);

        // T3: byte write merged on forward
        cyc(1'b1, 2'd2, 1'b1, 3'd0, 32'h23, 32'h0);
        cyc(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'hAA000000);
        idle(32'h0);
        check("t3_fwd", hrdata, 32'hAA223344);
        check("t3_commit_be", 32'(sram_be), 32'h8);

        // T4: read colliding with a write data phase while the buffer is full
        zeros = 0;
        cyc(1'b1, 2'd2, 1'b1, 3'd2, 32'h30, 32'h0);
        zeros += int'(!hready);
        cyc(1'b1, 2'd2, 1'b1, 3'd2, 32'h34, 32'hA5A50001);
        zeros += int'(!hready);
        cyc(1'b1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h5A5A0002);
        zeros += int'(!hready);
        check("t4_stall_commit_addr", 32'(sram_addr), 32'd12);
        cyc(1'b1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h5A5A0002);
        zeros += int'(!hready);
        idle(32'h0);
        zeros += int'(!hready);
        check("t4_wait_cycles", 32'(zeros), 32'd1);
        repeat (3) idle(32'h0);
        check("t4_sram_w0", smem[12], 32'hA5A50001);
        check("t4_sram_w1", smem[13], 32'h5A5A0002);

        // T5: access one word past the end
        cyc(1'b1, 2'd2, 1'b1, 3'd2, 32'h0, 32'h0);
        idle(32'h0BADC0DE);
        repeat (2) idle(32'h0);
        cyc(1'b1, 2'd2, 1'b0, 3'd2, MW * 4, 32'h0);
`ifdef HASTI_SRAM_ERR_EN
        check("t5_no_ce", 32'(sram_ce), 32'(0));
        idle(32'h0);
        check("t5_err1", {30'h0, hready, hresp}, 32'h1);
        idle(32'h0);
        check("t5_err2", {30'h0, hready, hresp}, 32'h3);
`else
        check("t5_wrap_addr", 32'(sram_addr), 32'h0);
        idle(32'h0);
        check("t5_wrap_data", hrdata, 32'h0BADC0DE);
        check("t5_okay", {30'h0, hready, hresp}, 32'h2);
`endif

        // T6: reset during a write data phase discards the write
        cyc(1'b1, 2'd2, 1'b1, 3'd2, 32'h50, 32'h0);
        idle(32'hCAFEF00D);
        repeat (2) idle(32'h0);
        cyc(1'b1, 2'd2, 1'b1, 3'd2, 32'h50, 32'h0);
        rst_nxt = 1'b1;
        idle(32'h12345678);
        rst_nxt = 1'b0;
        idle(32'h0);
        check("t6_hready", 32'(hready), 32'(1));
        check("t6_no_commit", 32'(sram_ce), 32'(0));
        cyc(1'b1, 2'd2, 1'b0, 3'd2, 32'h50, 32'h0);
        idle(32'h0);
        check("t6_rdata", hrdata, 32'hCAFEF00D);

        // Random traffic, holding the address phase across wait states
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!last_hready) begin
                drive(hsel, htrans, hwrite, hsize, haddr, hwdata);
            end else begin
                r  = $urandom_range(0, 99);
                a  = (r < 85) ? 32'($urandom_range(0, 15)) * 4 : 32'($urandom_range(0, MW + 8)) * 4;
                a  = a + 32'($urandom_range(0, 3));
                r  = $urandom_range(0, 15);
                sz = (r < 5) ? 3'd0 : (r < 10) ? 3'd1 : (r < 15) ? 3'd2 : 3'($urandom_range(3, 7));
                wd = last_acc_wr ? $urandom : hwdata;
                drive(1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), sz, a, wd);
            end
            #4;
        end

        // Drain and compare the SRAM image against the architectural memory
        repeat (4) idle(32'h0);
        for (int i = 0; i < int'(MW); i++) check("final_sram", smem[i], arch[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
